mdu: RTL and testbench
======================

# mdu

Multiply/divide unit in the EX stage, in parallel with the ALU. It takes the same forwarded rs/rt operands the ALU receives and executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency. It also owns the HI/LO architectural registers and serves MTHI/MTLO/MFHI/MFLO. The MFHI/MFLO value is muxed with the ALU Result into the E/M pipeline register. `busy` feeds the hazard unit's stall logic.

## Interface
- MULT_CYCLES, 5, cycles `busy` stays high for MULT/MULTU (≥1)
- DIV_CYCLES, 10, cycles `busy` stays high for DIV/DIVU (≥1)

- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- A  input  32  forwarded rs value (same operand as ALU A)
- B  input  32  forwarded rt value (same operand as ALU B)
- MDUop  input  4  0000 none, 0001 MULT, 0010 MULTU, 0011 DIV, 0100 DIVU, 0101 MTHI, 0110 MTLO, 0111 MFHI, 1000 MFLO, others = none
- busy  output  1  operation in flight
- HI  output  32  current HI register
- LO  output  32  current LO register
- MDResult  output  32  combinational: HI when MFHI, LO when MFLO, else 0

## Operation
- State: HI, LO, shadow hi_n/lo_n, down-counter cnt (width fits max(MULT_CYCLES, DIV_CYCLES)), busy flag. Two states: IDLE (busy=0) and RUN (busy=1).
- Launch: in IDLE, MDUop in {MULT, MULTU, DIV, DIVU} at a rising edge does three things:
  - computes the result from that cycle's A/B into hi_n/lo_n;
  - loads cnt with MULT_CYCLES or DIV_CYCLES;
  - enters RUN.
- MULT: {hi_n,lo_n} = $signed(A)*$signed(B), 64-bit. MULTU: unsigned 64-bit product.
- DIV: lo_n = signed quotient truncated toward zero; hi_n = remainder with the sign of the dividend A. DIVU: unsigned quotient/remainder.
- Overflow case 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0.
- Division by zero (B=0, DIV or DIVU): the operation still runs the full DIV_CYCLES; at commit HI/LO keep their prior values.
- RUN: cnt decrements each edge. At the edge where cnt reaches 0, HI←hi_n and LO←lo_n (except divide-by-zero) and the block returns to IDLE.
- MTHI/MTLO in IDLE: HI←A or LO←A at the edge.
- Any launch or MTHI/MTLO presented while busy=1 is ignored. The hazard unit stalls all of these, plus MFHI/MFLO, while busy=1 or a launch op sits in EX.
- MDResult reads HI/LO combinationally at all times. During RUN it returns the pre-operation value; stall logic ensures it is never consumed then.
- Ops 1001–1111 and 0000 change nothing.

## Timing
- Reset (reset_n low, asynchronous): HI=0, LO=0, busy=0, cnt=0, shadows=0, state IDLE, MDResult=0. Asserting it mid-RUN aborts the operation with no commit.
- Launch at edge E0 sets busy=1 immediately after E0.
- busy stays high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
- Commit occurs at edge E_N, with busy=0 after E_N. The new HI/LO are visible on HI/LO/MDResult in the cycle after E_N.
- A new launch is accepted at E_N+1 at the earliest: the first edge sampled with busy=0.
- Operands are captured only at E0. A/B changes during RUN have no effect.
- Back-to-back MTHI then MFHI: MFHI in the next cycle reads the new value (no internal bypass in the same cycle).
- Release of reset_n is synchronised externally. The first edge after release may launch.

## Test plan
- Reset: drive reset_n low mid-DIV (cycle 4 of 10). Required: busy=0, HI=LO=0 at once. After release, no commit ever appears.
- MULT A=0xFFFFFFFE (−2), B=3. Required: busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU on the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=−7 (0xFFFFFFF9), B=2. Required: busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 gives LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero: MTHI 0x1234, MTLO 0x5678, then DIVU B=0. Required: busy 10 cycles, HI=0x1234 and LO=0x5678 unchanged.
- Busy blocking: launch MULT 2×3, then on cycle 2 present DIV 9/3 and MTLO 0xAAAA. Required: both ignored, final HI=0, LO=6, busy high 5 cycles total.
- MFHI/MFLO: after MTHI 0xDEADBEEF, MFHI the next cycle gives MDResult=0xDEADBEEF. MFLO gives LO. MDUop=none gives MDResult=0.

Source files
------------

// File: rtl/mdu_if.sv
// Operand/op bus between the EX stage and the multiply/divide unit.
// Signal names follow the pipeline's existing MDU port names.
interface mdu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDUop;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDResult;

    modport master (output A, B, MDUop, input busy, HI, LO, MDResult);
    modport slave  (input A, B, MDUop, output busy, HI, LO, MDResult);
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at launch
// into shadow registers and committed after a fixed latency.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  reset_n,
    mdu_if.slave  bus
);
    localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;
    localparam logic [3:0] OP_MFHI  = 4'b0111;
    localparam logic [3:0] OP_MFLO  = 4'b1000;

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   hin_q, hin_d, lon_q, lon_d;
    logic          divz_q, divz_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_safe, bm_safe;
    logic [31:0] uq, ur, mq, mr, sq, sr;

    assign prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

    // Signed divide via magnitudes; the zero-divisor substitution only keeps the
    // datapath defined, since the commit is suppressed in that case.
    assign a_mag   = bus.A[31] ? -bus.A : bus.A;
    assign b_mag   = bus.B[31] ? -bus.B : bus.B;
    assign b_safe  = (bus.B == '0) ? 32'd1 : bus.B;
    assign bm_safe = (bus.B == '0) ? 32'd1 : b_mag;
    assign uq      = bus.A / b_safe;
    assign ur      = bus.A % b_safe;
    assign mq      = a_mag / bm_safe;
    assign mr      = a_mag % bm_safe;
    assign sq      = (bus.A[31] ^ bus.B[31]) ? -mq : mq;
    assign sr      = bus.A[31] ? -mr : mr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            hin_q   <= '0;
            lon_q   <= '0;
            divz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hin_q   <= hin_d;
            lon_q   <= lon_d;
            divz_q  <= divz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hin_d   = hin_q;
        lon_d   = lon_q;
        divz_d  = divz_q;
        case (state_q)
            IDLE: begin
                case (bus.MDUop)
                    OP_MULT: begin
                        {hin_d, lon_d} = prod_s;
                        divz_d  = 1'b0;
                        cnt_d   = CW'(MULT_CYCLES);
                        state_d = RUN;
                    end
                    OP_MULTU: begin
                        {hin_d, lon_d} = prod_u;
                        divz_d  = 1'b0;
                        cnt_d   = CW'(MULT_CYCLES);
                        state_d = RUN;
                    end
                    OP_DIV: begin
                        hin_d   = sr;
                        lon_d   = sq;
                        divz_d  = (bus.B == '0);
                        cnt_d   = CW'(DIV_CYCLES);
                        state_d = RUN;
                    end
                    OP_DIVU: begin
                        hin_d   = ur;
                        lon_d   = uq;
                        divz_d  = (bus.B == '0);
                        cnt_d   = CW'(DIV_CYCLES);
                        state_d = RUN;
                    end
                    OP_MTHI: hi_d = bus.A;
                    OP_MTLO: lo_d = bus.A;
                    default: ;
                endcase
            end
            RUN: begin
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (!divz_q) begin
                        hi_d = hin_q;
                        lo_d = lon_q;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;
    assign bus.MDResult = (bus.MDUop == OP_MFHI) ? hi_q :
                          (bus.MDUop == OP_MFLO) ? lo_q : '0;
endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: reset abort, mult/div results and latency,
// divide-by-zero, busy blocking, back-to-back launch and MFHI/MFLO reads.
module tb_mdu;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc;

    mdu_if bus ();

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op for one edge, then count cycles busy stays high (bounded).
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        bus.MDUop = op; bus.A = a; bus.B = b;
        tick();
        bus.MDUop = 4'd0;
        cycles = 0;
        while (bus.busy && cycles < 50) begin
            cycles++;
            tick();
        end
    endtask

    task automatic test_reset();
        bus.MDUop = 4'd0; bus.A = '0; bus.B = '0;
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.HI !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 0", bus.HI); end
        n_checks++; if (bus.LO !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 0", bus.LO); end
        n_checks++; if (bus.MDResult !== 32'h0) begin n_fail++; $display("FAIL reset_mdr got %h want 0", bus.MDResult); end
        @(negedge clk); reset_n = 1'b1;
        // DIV 100/5 aborted by reset in its 4th busy cycle
        bus.MDUop = 4'b0011; bus.A = 32'd100; bus.B = 32'd5;
        tick();
        bus.MDUop = 4'd0;
        tick(); tick(); tick();
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort_prebusy got %b want 1", bus.busy); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", bus.busy); end
        n_checks++; if ({bus.HI, bus.LO} !== 64'h0) begin n_fail++; $display("FAIL abort_hilo got %h want 0", {bus.HI, bus.LO}); end
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        n_checks++; if ({bus.busy, bus.HI, bus.LO} !== 65'h0) begin n_fail++; $display("FAIL abort_nocommit got %h want 0", {bus.busy, bus.HI, bus.LO}); end
    endtask

    task automatic test_mult();
        run_op(4'b0001, 32'hFFFF_FFFE, 32'd3, cyc);
        n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL mult_lat got %0d want 5", cyc); end
        n_checks++; if ({bus.HI, bus.LO} !== 64'hFFFF_FFFF_FFFF_FFFA) begin n_fail++; $display("FAIL mult_res got %h want fffffffffffffffa", {bus.HI, bus.LO}); end
        run_op(4'b0010, 32'hFFFF_FFFE, 32'd3, cyc);
        n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL multu_lat got %0d want 5", cyc); end
        n_checks++; if ({bus.HI, bus.LO} !== 64'h0000_0002_FFFF_FFFA) begin n_fail++; $display("FAIL multu_res got %h want 00000002fffffffa", {bus.HI, bus.LO}); end
    endtask

    task automatic test_div();
        run_op(4'b0011, 32'hFFFF_FFF9, 32'd2, cyc);
        n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL div_lat got %0d want 10", cyc); end
        n_checks++; if ({bus.HI, bus.LO} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL div_res got %h want fffffffffffffffd", {bus.HI, bus.LO}); end
        run_op(4'b0100, 32'd7, 32'd2, cyc);
        n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL divu_lat got %0d want 10", cyc); end
        n_checks++; if ({bus.HI, bus.LO} !== 64'h0000_0001_0000_0003) begin n_fail++; $display("FAIL divu_res got %h want 0000000100000003", {bus.HI, bus.LO}); end
        run_op(4'b0011, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        n_checks++; if ({bus.HI, bus.LO} !== 64'h0000_0000_8000_0000) begin n_fail++; $display("FAIL div_ovf got %h want 0000000080000000", {bus.HI, bus.LO}); end
    endtask

    task automatic test_divzero();
        bus.MDUop = 4'b0101; bus.A = 32'h1234; tick();
        bus.MDUop = 4'b0110; bus.A = 32'h5678; tick();
        run_op(4'b0100, 32'd99, 32'd0, cyc);
        n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL divz_lat got %0d want 10", cyc); end
        n_checks++; if ({bus.HI, bus.LO} !== 64'h0000_1234_0000_5678) begin n_fail++; $display("FAIL divz_keep got %h want 0000123400005678", {bus.HI, bus.LO}); end
        run_op(4'b0011, 32'd5, 32'd0, cyc);
        n_checks++; if ({bus.HI, bus.LO} !== 64'h0000_1234_0000_5678) begin n_fail++; $display("FAIL divsz_keep got %h want 0000123400005678", {bus.HI, bus.LO}); end
    endtask

    task automatic test_busy_block();
        bus.MDUop = 4'b0101; bus.A = 32'h0; tick();
        bus.MDUop = 4'b0110; bus.A = 32'h0; tick();
        bus.MDUop = 4'b0001; bus.A = 32'd2; bus.B = 32'd3;
        tick();
        cyc = 0;
        while (bus.busy && cyc < 50) begin
            cyc++;
            if (cyc == 1) begin bus.MDUop = 4'b0011; bus.A = 32'd9; bus.B = 32'd3; end
            else if (cyc == 2) begin bus.MDUop = 4'b0110; bus.A = 32'hAAAA; end
            else bus.MDUop = 4'd0;
            if (cyc == 3) begin
                n_checks++; if (bus.LO !== 32'h0) begin n_fail++; $display("FAIL block_midrun_lo got %h want 0", bus.LO); end
            end
            tick();
        end
        bus.MDUop = 4'd0;
        n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL block_lat got %0d want 5", cyc); end
        n_checks++; if ({bus.HI, bus.LO} !== 64'h0000_0000_0000_0006) begin n_fail++; $display("FAIL block_res got %h want 0000000000000006", {bus.HI, bus.LO}); end
        tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL block_idle got %b want 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        run_op(4'b0010, 32'h0001_0000, 32'h0001_0000, cyc);
        run_op(4'b0100, 32'd20, 32'd6, cyc);
        n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL b2b_lat got %0d want 10", cyc); end
        n_checks++; if ({bus.HI, bus.LO} !== 64'h0000_0002_0000_0003) begin n_fail++; $display("FAIL b2b_res got %h want 0000000200000003", {bus.HI, bus.LO}); end
    endtask

    task automatic test_mfhi_mflo();
        bus.MDUop = 4'b0110; bus.A = 32'hCAFE_F00D; tick();
        bus.MDUop = 4'b0101; bus.A = 32'hDEAD_BEEF; #1;
        n_checks++; if (bus.MDResult !== 32'h0) begin n_fail++; $display("FAIL mthi_mdr got %h want 0", bus.MDResult); end
        tick();
        bus.MDUop = 4'b0111; bus.A = 32'h0; #1;
        n_checks++; if (bus.MDResult !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mfhi got %h want deadbeef", bus.MDResult); end
        bus.MDUop = 4'b1000; #1;
        n_checks++; if (bus.MDResult !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL mflo got %h want cafef00d", bus.MDResult); end
        bus.MDUop = 4'd0; #1;
        n_checks++; if (bus.MDResult !== 32'h0) begin n_fail++; $display("FAIL mdr_none got %h want 0", bus.MDResult); end
        bus.MDUop = 4'b1111; bus.A = 32'h1; bus.B = 32'h1; tick();
        bus.MDUop = 4'd0;
        n_checks++; if ({bus.busy, bus.HI, bus.LO} !== {1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL op_reserved got %h want 0deadbeefcafef00d", {bus.busy, bus.HI, bus.LO}); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_divzero();
        test_busy_block();
        test_back_to_back();
        test_mfhi_mflo();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
